// File: rtl/riscv_pkg.sv
// Shared RV32I/M decode types, opcode constants and small mapping helpers.
package riscv_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_PASS_B,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_e;

    typedef struct packed {
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        alu_op_e            alu_op;
        logic               alu_src_imm;
        logic               alu_src_pc;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        mem_size_e          mem_size;
        logic               mem_unsigned;
        logic               branch;
        logic               jump;
        logic               uses_rs1;
        logic               uses_rs2;
        logic [RV_XLEN-1:0] imm;
    } decoded_inst_t;

    // Base integer ALU op from funct3; alt selects SUB/SRA on the two funct3 codes that have them.
    function automatic alu_op_e alu_base_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // RV32M op from funct3.
    function automatic alu_op_e alu_m_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

    // Access size from the low funct3 bits; the unused code 11 reads as a word.
    function automatic mem_size_e mem_size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return MEM_B;
            2'b01:   return MEM_H;
            default: return MEM_W;
        endcase
    endfunction

endpackage

// File: rtl/decode_core.sv
// Purely combinational RV32I/M instruction decoder with illegal-encoding detection.
module decode_core
    import riscv_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]   instr,
    output decoded_inst_t dec,
    output logic          illegal
);

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RV_XLEN-1:0] imm_i;
    logic [RV_XLEN-1:0] imm_s;
    logic [RV_XLEN-1:0] imm_b;
    logic [RV_XLEN-1:0] imm_u;
    logic [RV_XLEN-1:0] imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'h000};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Decode by opcode class, then squash side effects of illegal or rd=x0 instructions.
    always_comb begin
        dec         = '0;
        illegal     = 1'b0;
        dec.opcode  = opcode;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct3  = funct3;
        dec.funct7  = funct7;
        case (opcode)
            OP_LUI: begin
                dec.alu_op      = ALU_PASS_B;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                dec.imm         = imm_u;
            end
            OP_AUIPC: begin
                dec.alu_src_imm = 1'b1;
                dec.alu_src_pc  = 1'b1;
                dec.reg_write   = 1'b1;
                dec.imm         = imm_u;
            end
            OP_JAL: begin
                dec.alu_src_imm = 1'b1;
                dec.alu_src_pc  = 1'b1;
                dec.reg_write   = 1'b1;
                dec.jump        = 1'b1;
                dec.imm         = imm_j;
            end
            OP_JALR: begin
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                dec.jump        = 1'b1;
                dec.uses_rs1    = 1'b1;
                dec.imm         = imm_i;
                illegal         = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                dec.alu_op   = ALU_SUB;
                dec.branch   = 1'b1;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                dec.imm      = imm_b;
                illegal      = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                dec.alu_src_imm  = 1'b1;
                dec.reg_write    = 1'b1;
                dec.mem_read     = 1'b1;
                dec.mem_to_reg   = 1'b1;
                dec.uses_rs1     = 1'b1;
                dec.imm          = imm_i;
                dec.mem_size     = mem_size_of(funct3);
                dec.mem_unsigned = funct3[2];
                illegal          = !((funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                                     (funct3 == F3_LBU) || (funct3 == F3_LHU));
            end
            OP_STORE: begin
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
                dec.uses_rs1    = 1'b1;
                dec.uses_rs2    = 1'b1;
                dec.imm         = imm_s;
                dec.mem_size    = mem_size_of(funct3);
                illegal         = !((funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW));
            end
            OP_IMM: begin
                dec.alu_op      = alu_base_op(funct3, (funct3 == 3'b101) && funct7[5]);
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                dec.uses_rs1    = 1'b1;
                dec.imm         = imm_i;
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end
            end
            OP_OP: begin
                dec.reg_write = 1'b1;
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
                if (ENABLE_M && (funct7 == F7_MULDIV)) begin
                    dec.alu_op = alu_m_op(funct3);
                end else begin
                    dec.alu_op = alu_base_op(funct3, funct7[5]);
                end
                case (funct7)
                    F7_BASE:   illegal = 1'b0;
                    F7_ALT:    illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
                    F7_MULDIV: illegal = !ENABLE_M;
                    default:   illegal = 1'b1;
                endcase
            end
            OP_FENCE, OP_SYSTEM: begin
                illegal = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_core behind a two-entry skid buffer with flush.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32,
    parameter bit ENABLE_M = 1'b1,
    parameter bit SKID_EN  = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         instruction_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [PC_WIDTH-1:0] out_pc_o,
    output decoded_inst_t       out_dec_o,
    output logic                illegal_o
);

    if (XLEN != RV_XLEN) begin : g_xlen_check
        $error("decode_stage: XLEN must be 32");
    end

    decoded_inst_t       core_dec;
    logic                core_illegal;
    buf_state_e          state_reg, state_next;
    logic [PC_WIDTH-1:0] out_pc_reg, out_pc_next, skid_pc_reg, skid_pc_next;
    decoded_inst_t       out_dec_reg, out_dec_next, skid_dec_reg, skid_dec_next;
    logic                out_ill_reg, out_ill_next, skid_ill_reg, skid_ill_next;
    logic                in_ready_reg;
    logic                accept;
    logic                drain;

    decode_core #(
        .ENABLE_M (ENABLE_M)
    ) u_decode_core (
        .instr   (instruction_i),
        .dec     (core_dec),
        .illegal (core_illegal)
    );

    assign out_valid_o = (state_reg != BUF_EMPTY);
    assign out_pc_o    = out_pc_reg;
    assign out_dec_o   = out_dec_reg;
    assign illegal_o   = out_ill_reg;
    assign accept      = in_valid_i && in_ready_o;
    assign drain       = out_valid_o && out_ready_i;

    // With the skid entry, ready is a pure register; without it, ready looks through to the sink.
    if (SKID_EN) begin : g_skid_ready
        assign in_ready_o = in_ready_reg;
    end else begin : g_single_ready
        assign in_ready_o = !out_valid_o || out_ready_i;
    end

    // Buffer next-state and data movement; flush empties the buffer and ignores the input.
    always_comb begin
        state_next    = state_reg;
        out_pc_next   = out_pc_reg;
        out_dec_next  = out_dec_reg;
        out_ill_next  = out_ill_reg;
        skid_pc_next  = skid_pc_reg;
        skid_dec_next = skid_dec_reg;
        skid_ill_next = skid_ill_reg;
        if (flush_i) begin
            state_next = BUF_EMPTY;
        end else begin
            case (state_reg)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_next   = BUF_ONE;
                        out_pc_next  = pc_i;
                        out_dec_next = core_dec;
                        out_ill_next = core_illegal;
                    end
                end
                BUF_ONE: begin
                    if (accept && drain) begin
                        out_pc_next  = pc_i;
                        out_dec_next = core_dec;
                        out_ill_next = core_illegal;
                    end else if (accept) begin
                        state_next    = BUF_TWO;
                        skid_pc_next  = pc_i;
                        skid_dec_next = core_dec;
                        skid_ill_next = core_illegal;
                    end else if (drain) begin
                        state_next = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (drain) begin
                        state_next   = BUF_ONE;
                        out_pc_next  = skid_pc_reg;
                        out_dec_next = skid_dec_reg;
                        out_ill_next = skid_ill_reg;
                    end
                end
                default: begin
                    state_next = BUF_EMPTY;
                end
            endcase
        end
    end

    // State and data registers; ready is precomputed from the next state so it is registered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg    <= BUF_EMPTY;
            out_pc_reg   <= '0;
            out_dec_reg  <= '0;
            out_ill_reg  <= 1'b0;
            skid_pc_reg  <= '0;
            skid_dec_reg <= '0;
            skid_ill_reg <= 1'b0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            out_pc_reg   <= out_pc_next;
            out_dec_reg  <= out_dec_next;
            out_ill_reg  <= out_ill_next;
            skid_pc_reg  <= skid_pc_next;
            skid_dec_reg <= skid_dec_next;
            skid_ill_reg <= skid_ill_next;
            in_ready_reg <= (state_next != BUF_TWO);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised + directed bench for decode_stage against a FIFO/decode reference model.
module tb_decode_stage;
    import riscv_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic [31:0]   instr, pc;
    logic          in_ready_a, out_valid_a, ill_a;
    logic          in_ready_b, out_valid_b, ill_b;
    logic [31:0]   out_pc_a, out_pc_b;
    decoded_inst_t dec_a, dec_b;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;
    entry_t q[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_WIDTH(32), .ENABLE_M(1'b1), .SKID_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
        .instruction_i(instr), .pc_i(pc), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
        .out_pc_o(out_pc_a), .out_dec_o(dec_a), .illegal_o(ill_a));

    decode_stage #(.XLEN(32), .PC_WIDTH(32), .ENABLE_M(1'b0), .SKID_EN(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
        .instruction_i(instr), .pc_i(pc), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
        .out_pc_o(out_pc_b), .out_dec_o(dec_b), .illegal_o(ill_b));

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkdec(input string nm, input decoded_inst_t act, input decoded_inst_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Two's-complement value of a bits-wide field.
    function automatic logic [31:0] sx(input int unsigned v, input int bits);
        int s;
        s = int'(v);
        if (v >= (32'd1 << (bits - 1))) s = s - (1 << bits);
        return 32'(s);
    endfunction

    function automatic alu_op_e ref_base(input logic [2:0] f3, input logic alt);
        alu_op_e r;
        case (f3)
            0: r = ALU_ADD;  1: r = ALU_SLL; 2: r = ALU_SLT; 3: r = ALU_SLTU;
            4: r = ALU_XOR;  5: r = ALU_SRL; 6: r = ALU_OR;  default: r = ALU_AND;
        endcase
        if (alt && f3 == 0) r = ALU_SUB;
        if (alt && f3 == 5) r = ALU_SRA;
        return r;
    endfunction

    // Reference decode written per instruction class from the ISA rules.
    function automatic void ref_dec(input logic [31:0] ins, input bit en_m,
                                    output decoded_inst_t d, output logic ill);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        d = '0;
        ill = 1'b0;
        d.opcode = op; d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
        d.funct3 = f3; d.funct7 = f7;
        if (op == 7'h37) begin
            d.alu_op = ALU_PASS_B; d.alu_src_imm = 1; d.reg_write = 1;
            d.imm = ins & 32'hFFFFF000;
        end else if (op == 7'h17) begin
            d.alu_src_imm = 1; d.alu_src_pc = 1; d.reg_write = 1;
            d.imm = ins & 32'hFFFFF000;
        end else if (op == 7'h6F) begin
            d.alu_src_imm = 1; d.alu_src_pc = 1; d.reg_write = 1; d.jump = 1;
            d.imm = sx({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
        end else if (op == 7'h67) begin
            d.alu_src_imm = 1; d.reg_write = 1; d.jump = 1; d.uses_rs1 = 1;
            d.imm = sx(ins[31:20], 12);
            ill = (f3 != 0);
        end else if (op == 7'h63) begin
            d.alu_op = ALU_SUB; d.branch = 1; d.uses_rs1 = 1; d.uses_rs2 = 1;
            d.imm = sx({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
            ill = (f3 == 2 || f3 == 3);
        end else if (op == 7'h03 || op == 7'h23) begin
            d.alu_src_imm = 1; d.uses_rs1 = 1;
            d.mem_size = (f3 == 0 || f3 == 4) ? MEM_B : (f3 == 1 || f3 == 5) ? MEM_H : MEM_W;
            if (op == 7'h03) begin
                d.reg_write = 1; d.mem_read = 1; d.mem_to_reg = 1; d.mem_unsigned = f3[2];
                d.imm = sx(ins[31:20], 12);
                ill = (f3 == 3 || f3 >= 6);
            end else begin
                d.mem_write = 1; d.uses_rs2 = 1;
                d.imm = sx({ins[31:25], ins[11:7]}, 12);
                ill = (f3 > 2);
            end
        end else if (op == 7'h13) begin
            d.alu_op = ref_base(f3, f3 == 5 && f7 == 7'h20);
            if (f3 == 5 && f7 != 0 && f7 != 7'h20) d.alu_op = ref_base(f3, f7[5]);
            d.alu_src_imm = 1; d.reg_write = 1; d.uses_rs1 = 1;
            d.imm = sx(ins[31:20], 12);
            ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
        end else if (op == 7'h33) begin
            d.reg_write = 1; d.uses_rs1 = 1; d.uses_rs2 = 1;
            if (f7 == 1 && en_m) d.alu_op = alu_op_e'(int'(ALU_MUL) + int'(f3));
            else d.alu_op = ref_base(f3, f7[5]);
            ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && en_m));
        end else if (op == 7'h0F || op == 7'h73) begin
            ill = 1'b0;
        end else begin
            ill = 1'b1;
        end
        if (ill) begin
            d.reg_write = 0; d.mem_read = 0; d.mem_write = 0; d.branch = 0; d.jump = 0;
        end
        if (d.rd == 0) d.reg_write = 0;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6F;  3: r[6:0] = 7'h67;
            4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;  6: r[6:0] = 7'h23;  7: r[6:0] = 7'h13;
            8: r[6:0] = 7'h33;  9: r[6:0] = 7'h0F; 10: r[6:0] = 7'h73;
            default: ;
        endcase
        if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        end
        return r;
    endfunction

    // Reference FIFO: advance on every edge from the model's own valid/ready.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready)
                    $display("xfer pc=%h ins=%h", q[0].pc, q[0].ins);
                if (flush) begin
                    q.delete();
                end else begin
                    case ({in_valid && q.size() < 2, q.size() > 0 && out_ready})
                        2'b10: q.push_back({pc, instr});
                        2'b01: void'(q.pop_front());
                        2'b11: begin void'(q.pop_front()); q.push_back({pc, instr}); end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    initial begin
        decoded_inst_t de;
        logic          il;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk1("valid_a", out_valid_a, q.size() > 0);
                chk1("ready_a", in_ready_a, q.size() < 2);
                chk1("valid_b", out_valid_b, q.size() > 0);
                chk1("ready_b", in_ready_b, q.size() < 2);
                if (q.size() > 0) begin
                    ref_dec(q[0].ins, 1'b1, de, il);
                    chkdec("dec_a", dec_a, de);
                    chk1("ill_a", ill_a, il);
                    chk32("pc_a", out_pc_a, q[0].pc);
                    ref_dec(q[0].ins, 1'b0, de, il);
                    chkdec("dec_b", dec_b, de);
                    chk1("ill_b", ill_b, il);
                    chk32("pc_b", out_pc_b, q[0].pc);
                end
            end
        end
    end

    task automatic present(input logic [31:0] ins, input logic [31:0] p);
        in_valid = 1'b1;
        instr    = ins;
        pc       = p;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        decoded_inst_t de;
        logic          il;
        logic [31:0]   bp_ins [4];
        logic [31:0]   dr_pc  [4];
        int            dr_cyc [4];
        int            idx, ndr;
        logic          acc;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0;
        bp_ins[0] = 32'h00500093; bp_ins[1] = 32'h4020D1B3;
        bp_ins[2] = 32'hFFC12283; bp_ins[3] = 32'h022080B3;

        // Pin the reference decoder itself with hand-computed values.
        ref_dec(32'hFFC12283, 1'b1, de, il);
        chk32("model_lw_imm", de.imm, 32'hFFFFFFFC);
        ref_dec(32'h4020D1B3, 1'b1, de, il);
        chk32("model_sra_op", 32'(de.alu_op), 32'(ALU_SRA));
        ref_dec(32'h022080B3, 1'b0, de, il);
        chk1("model_mul_nom_ill", il, 1'b1);

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk1("rst_valid", out_valid_a, 1'b0);
        chk1("rst_ready", in_ready_a, 1'b1);
        chk32("rst_pc", out_pc_a, 32'h0);
        chkdec("rst_dec", dec_a, '0);
        chk1("rst_ill", ill_a, 1'b0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        present(32'h00500093, 32'h100);
        chk1("addi_valid", out_valid_a, 1'b1);
        chk32("addi_alu", 32'(dec_a.alu_op), 32'(ALU_ADD));
        chk32("addi_imm", dec_a.imm, 32'd5);
        chk1("addi_src_imm", dec_a.alu_src_imm, 1'b1);
        chk1("addi_rw", dec_a.reg_write, 1'b1);
        chk32("addi_rd", 32'(dec_a.rd), 32'd1);
        chk1("addi_ill", ill_a, 1'b0);

        present(32'h4020D1B3, 32'h104);
        chk32("sra_alu", 32'(dec_a.alu_op), 32'(ALU_SRA));
        chk1("sra_rs2", dec_a.uses_rs2, 1'b1);

        present(32'hFFC12283, 32'h108);
        chk32("lw_imm", dec_a.imm, 32'hFFFFFFFC);
        chk32("lw_size", 32'(dec_a.mem_size), 32'(MEM_W));
        chk1("lw_mrd", dec_a.mem_read, 1'b1);
        chk1("lw_m2r", dec_a.mem_to_reg, 1'b1);

        present(32'h022080B3, 32'h10C);
        chk32("mul_alu", 32'(dec_a.alu_op), 32'(ALU_MUL));
        chk1("mul_ill", ill_a, 1'b0);
        chk1("mul_nom_ill", ill_b, 1'b1);
        chk1("mul_nom_rw", dec_b.reg_write, 1'b0);

        present(32'hFFFFFFFF, 32'h110);
        chk1("ones_ill", ill_a, 1'b1);
        repeat (2) @(negedge clk);

        // Backpressure: sink stalled for three cycles while four instructions stream in.
        idx = 0; ndr = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            out_ready = (cyc >= 3);
            if (idx < 4) begin
                in_valid = 1'b1; instr = bp_ins[idx]; pc = 32'h200 + 32'(4 * idx);
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready_a;
            if (cyc == 1) chk1("bp_ready_one", in_ready_a, 1'b1);
            if (cyc == 2) chk1("bp_ready_low", in_ready_a, 1'b0);
            if (cyc == 1 || cyc == 2) chk32("bp_stable_pc", out_pc_a, 32'h200);
            if (out_valid_a && out_ready && ndr < 4) begin
                dr_pc[ndr] = out_pc_a; dr_cyc[ndr] = cyc; ndr++;
            end
            @(negedge clk);
            if (acc) idx++;
        end
        chk32("bp_drains", 32'(ndr), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ndr) begin
                chk32("bp_order", dr_pc[k], 32'h200 + 32'(4 * k));
                chk32("bp_cycle", 32'(dr_cyc[k]), 32'(3 + k));
            end
        end

        // Flush from TWO with an input presented.
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00500093; pc = 32'h300;
        @(negedge clk);
        instr = 32'h4020D1B3; pc = 32'h304;
        @(negedge clk);
        chk1("fl_full", in_ready_a, 1'b0);
        flush = 1'b1; pc = 32'h308;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk1("fl_valid", out_valid_a, 1'b0);
        chk1("fl_ready", in_ready_a, 1'b1);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("fl_gone", out_valid_a, 1'b0);
        end
        // Flush from ONE drops an input even though ready is high.
        in_valid = 1'b1; pc = 32'h310;
        @(negedge clk);
        flush = 1'b1; pc = 32'h314;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk1("fl1_valid", out_valid_a, 1'b0);

        // Reset with two entries buffered, overriding flush and handshakes.
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00500093; pc = 32'h400;
        @(negedge clk);
        pc = 32'h404;
        @(negedge clk);
        chk1("mr_full", in_ready_a, 1'b0);
        rst_n = 1'b0; pc = 32'h408; out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk1("mr_valid", out_valid_a, 1'b0);
        chk1("mr_ready", in_ready_a, 1'b1);
        chk32("mr_pc", out_pc_a, 32'h0);
        chkdec("mr_dec", dec_a, '0);
        chk1("mr_ill", ill_a, 1'b0);
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk1("mr_no_stale", out_valid_a, 1'b0);
        end

        // Random valid/ready/flush/reset stress, checked every cycle by the compare process.
        pc = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 400) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            instr     = rand_ins();
            pc        = pc + 32'd4;
            @(negedge clk);
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
